serial_bus_sequencer: RTL

- Parametrised control sequencer for the serial CPU's external memory link.
- Drives instruction fetch (PC out, instruction in) and load/store transactions (address out, data in/out) over a LINK_W-bit serial bus to the microcontroller-side memory.
- Emits the shift/load strobes and bus-select lines consumed by the PC, MAR, MDR and instruction registers.
- Adds the following over the previous fixed 16-bit controller:
  - generic beat count;
  - wait-state timeout with bounded retry;
  - a sticky error state;
  - a done/halt indication.

---
 rtl/serial_bus_sequencer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/serial_bus_sequencer.sv
// Control sequencer for the serial CPU memory link: instruction fetch, load and store
// bursts with bounded retry, sticky error and halt. Define SEQ_TIMEOUT_EN for wait-state timeouts.
module serial_bus_sequencer #(
  parameter int WORD_W      = 16,
  parameter int LINK_W      = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ard_receive_ready,
  input  logic                           ard_data_ready,
  input  logic                           is_mem,
  input  logic                           is_load,
  input  logic                           is_store,
  input  logic                           valid_instr,
  input  logic                           halt,
  output logic                           pc_shift_out,
  output logic                           mar_shift_out,
  output logic                           mdr_shift_out,
  output logic                           mdr_shift_in,
  output logic                           instr_shift_in,
  output logic                           bus_pc,
  output logic                           bus_mar,
  output logic                           bus_mdr,
  output logic                           go,
  output logic                           pc_en,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int BEATS   = (WORD_W / LINK_W > 1) ? WORD_W / LINK_W : 1;
  localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  typedef enum logic [3:0] {
    FETCH_WAIT, PC_OUT, INSTR_WAIT, INSTR_IN, CHECK, EXEC,
    ADDR_WAIT, ADDR_OUT, DATA_OUT, DATA_WAIT, DATA_IN, HALTED, ERR
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_req;
  logic               timeout;
  logic               last_beat;

  assign last_beat = (beat_q == LAST_BEAT);
  assign retry_cnt = retry_q;

`ifdef SEQ_TIMEOUT_EN
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
  logic [WAIT_W-1:0] wait_q;
  logic              in_wait;
  assign in_wait = state_q inside {FETCH_WAIT, INSTR_WAIT, ADDR_WAIT, DATA_WAIT};
  assign timeout = in_wait && (wait_q == WAIT_LAST);
`else
  // The timeout budget only matters when the wait counter is built.
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // NOTE: combinational next-state uses blocking '=' with defaults first, so no latches appear.
  always_comb begin
    state_d   = state_q;
    beat_d    = '0;
    retry_d   = retry_q;
    retry_req = 1'b0;
    case (state_q)
      FETCH_WAIT: if (ard_receive_ready) state_d = PC_OUT;     else retry_req = timeout;
      INSTR_WAIT: if (ard_data_ready)    state_d = INSTR_IN;   else retry_req = timeout;
      ADDR_WAIT:  if (ard_receive_ready) state_d = ADDR_OUT;   else retry_req = timeout;
      DATA_WAIT:  if (ard_data_ready)    state_d = DATA_IN;    else retry_req = timeout;
      PC_OUT:     if (last_beat) state_d = INSTR_WAIT; else beat_d = beat_q + 1'b1;
      INSTR_IN:   if (last_beat) state_d = CHECK;      else beat_d = beat_q + 1'b1;
      CHECK: begin
        if (!valid_instr) retry_req = 1'b1;
        else if (halt)    state_d = HALTED;
        else begin
          state_d = EXEC;
          retry_d = '0;
        end
      end
      EXEC: state_d = is_mem ? ADDR_WAIT : FETCH_WAIT;
      ADDR_OUT: begin
        if (!last_beat)              beat_d  = beat_q + 1'b1;
        else if (is_load ^ is_store) state_d = is_load ? DATA_WAIT : DATA_OUT;
        else                         state_d = ERR;
      end
      DATA_OUT, DATA_IN: begin
        if (!last_beat) beat_d = beat_q + 1'b1;
        else begin
          state_d = FETCH_WAIT;
          retry_d = '0;
        end
      end
      HALTED:  state_d = HALTED;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
    // Memory-phase retries restart the address transfer; all others restart the fetch.
    if (retry_req) begin
      if (retry_q == RETRY_MAX) state_d = ERR;
      else begin
        retry_d = retry_q + 1'b1;
        state_d = (state_q inside {ADDR_WAIT, DATA_WAIT}) ? ADDR_WAIT : FETCH_WAIT;
      end
    end
  end

  // NOTE: outputs are registered from the next state, so each strobe is high exactly while
  // the state register holds the matching state and no decode glitches reach the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH_WAIT;
      beat_q         <= '0;
      retry_q        <= '0;
      pc_shift_out   <= 1'b0;
      mar_shift_out  <= 1'b0;
      mdr_shift_out  <= 1'b0;
      mdr_shift_in   <= 1'b0;
      instr_shift_in <= 1'b0;
      bus_pc         <= 1'b0;
      bus_mar        <= 1'b0;
      bus_mdr        <= 1'b0;
      go             <= 1'b0;
      pc_en          <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wait_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      retry_q        <= retry_d;
      pc_shift_out   <= (state_d == PC_OUT);
      bus_pc         <= (state_d == PC_OUT);
      mar_shift_out  <= (state_d == ADDR_OUT);
      bus_mar        <= (state_d == ADDR_OUT);
      mdr_shift_out  <= (state_d == DATA_OUT);
      bus_mdr        <= (state_d == DATA_OUT);
      mdr_shift_in   <= (state_d == DATA_IN);
      instr_shift_in <= (state_d == INSTR_IN);
      go             <= (state_d == EXEC);
      pc_en          <= (state_d == EXEC);
      done           <= (state_d == HALTED);
      error          <= (state_d == ERR);
`ifdef SEQ_TIMEOUT_EN
      if (!in_wait || retry_req || (state_d != state_q)) wait_q <= '0;
      else                                               wait_q <= wait_q + 1'b1;
`endif
    end
  end

endmodule
